// File: rtl/vgachargen_color_capture.sv
// VGA loopback receiver: recovers raster timing from the sync pins, samples one pixel per
// 8x16 character cell and writes its 4-bit color code back into the color map.
module vgachargen_color_capture #(
  parameter  int unsigned SAMPLE_X           = 4,
  parameter  int unsigned SAMPLE_Y           = 8,
  parameter  int unsigned HD                 = 640,
  parameter  int unsigned HF                 = 16,
  parameter  int unsigned HR                 = 96,
  parameter  int unsigned HB                 = 48,
  parameter  int unsigned VD                 = 480,
  parameter  int unsigned VF                 = 10,
  parameter  int unsigned VR                 = 2,
  parameter  int unsigned VB                 = 33,
  localparam int unsigned BITMAP_H_PIXELS    = 8,
  localparam int unsigned BITMAP_V_PIXELS    = 16,
  localparam int unsigned CH_H_WIDTH         = 7,
  localparam int unsigned CH_V_WIDTH         = 5,
  localparam int unsigned COL_MAP_ADDR_WIDTH = CH_V_WIDTH + CH_H_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          hsync_n_i,
  input  logic                          vsync_n_i,
  input  logic [11:0]                   rgb_i,
  output logic                          map_we_o,
  output logic [COL_MAP_ADDR_WIDTH-1:0] map_addr_o,
  output logic [3:0]                    map_data_o,
  output logic                          locked_o,
  output logic                          frame_done_o,
  output logic                          bad_color_o,
  output logic                          sync_err_o
);

  localparam int unsigned CW     = 10;
  localparam int unsigned BX_W   = $clog2(BITMAP_H_PIXELS);
  localparam int unsigned BY_W   = $clog2(BITMAP_V_PIXELS);
  localparam int unsigned HTOTAL = HR + HB + HD + HF;
  localparam int unsigned VTOTAL = VR + VB + VD + VF;

  localparam logic [CW-1:0] H_LAST  = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(VTOTAL - 1);
  localparam logic [CW-1:0] V_END   = CW'(VTOTAL);
  localparam logic [CW-1:0] H_START = CW'(HR + HB);
  localparam logic [CW-1:0] H_STOP  = CW'(HR + HB + HD);
  localparam logic [CW-1:0] V_START = CW'(VR + VB);
  localparam logic [CW-1:0] V_STOP  = CW'(VR + VB + VD);

  localparam logic [CH_V_WIDTH-1:0] LAST_ROW = CH_V_WIDTH'(VD / BITMAP_V_PIXELS - 1);
  localparam logic [CH_H_WIDTH-1:0] LAST_COL = CH_H_WIDTH'(HD / BITMAP_H_PIXELS - 1);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_HLOCK  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  logic        hs_s1, hs_s2, vs_s1, vs_s2;
  logic [11:0] rgb_s1;
  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        vpend_q, vpend_d, vpend_eff;
  logic [1:0]  state_q, state_d;

  logic        hfall, vfall;
  logic        h_viol, v_viol, viol;
  logic        h_act, v_act, sample;
  logic [CW-1:0] x, y;
  logic [CH_V_WIDTH-1:0] cell_row;
  logic [CH_H_WIDTH-1:0] cell_col;
  logic        last_cell;
  logic [3:0]  code;
  logic        code_ok;

  // Counters describe the pixel currently held in stage 1, so the sample decision
  // and the registered write land two cycles after the pixel was on rgb_i.
  always_comb begin
    hfall     = hs_s2 & ~hs_s1;
    vfall     = vs_s2 & ~vs_s1;
    vpend_eff = vpend_q | vfall;

    if (hfall)                hcnt_d = '0;
    else if (hcnt_q == H_LAST) hcnt_d = hcnt_q;
    else                      hcnt_d = hcnt_q + CW'(1);

    vcnt_d  = vcnt_q;
    vpend_d = vpend_eff;
    if (hfall) begin
      vpend_d = 1'b0;
      if (vpend_eff)            vcnt_d = '0;
      else if (vcnt_q != V_END) vcnt_d = vcnt_q + CW'(1);
    end
  end

  always_comb begin
    h_viol = (state_q != S_SEARCH) &&
             (hfall ? (hcnt_q != H_LAST) : (hcnt_q == H_LAST));
    v_viol = (state_q == S_LOCKED) && hfall &&
             (vpend_eff ? (vcnt_q != V_LAST) : (vcnt_q == V_LAST));
    viol   = h_viol | v_viol;

    state_d = state_q;
    case (state_q)
      S_SEARCH: if (hfall) state_d = S_HLOCK;
      S_HLOCK: begin
        if (viol)                    state_d = S_SEARCH;
        else if (hfall && vpend_eff) state_d = S_LOCKED;
      end
      S_LOCKED: if (viol) state_d = S_SEARCH;
      default:  state_d = S_SEARCH;
    endcase
  end

  always_comb begin
    x         = hcnt_d - H_START;
    y         = vcnt_d - V_START;
    h_act     = (hcnt_d >= H_START) && (hcnt_d < H_STOP);
    v_act     = (vcnt_d >= V_START) && (vcnt_d < V_STOP);
    cell_row  = CH_V_WIDTH'(y >> BY_W);
    cell_col  = CH_H_WIDTH'(x >> BX_W);
    last_cell = (cell_row == LAST_ROW) && (cell_col == LAST_COL);
    sample    = (state_q == S_LOCKED) && !viol && h_act && v_act &&
                (x[BX_W-1:0] == BX_W'(SAMPLE_X)) &&
                (y[BY_W-1:0] == BY_W'(SAMPLE_Y));
  end

  // Inverse of the palette; black always maps to code 0 even though code 1 also displays black.
  always_comb begin
    code    = '0;
    code_ok = 1'b1;
    case (rgb_s1)
      12'h000: code = 4'h0;
      12'h00d: code = 4'h2;
      12'h00f: code = 4'h3;
      12'hd00: code = 4'h4;
      12'hf00: code = 4'h5;
      12'hd0d: code = 4'h6;
      12'hf0f: code = 4'h7;
      12'h0d0: code = 4'h8;
      12'h0f0: code = 4'h9;
      12'h0dd: code = 4'ha;
      12'h0ff: code = 4'hb;
      12'hdd0: code = 4'hc;
      12'hff0: code = 4'hd;
      12'hddd: code = 4'he;
      12'hfff: code = 4'hf;
      default: code_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hs_s1        <= 1'b1;
      hs_s2        <= 1'b1;
      vs_s1        <= 1'b1;
      vs_s2        <= 1'b1;
      rgb_s1       <= '0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      vpend_q      <= 1'b0;
      state_q      <= S_SEARCH;
      map_we_o     <= 1'b0;
      map_addr_o   <= '0;
      map_data_o   <= '0;
      locked_o     <= 1'b0;
      frame_done_o <= 1'b0;
      bad_color_o  <= 1'b0;
      sync_err_o   <= 1'b0;
    end else begin
      hs_s1        <= hsync_n_i;
      hs_s2        <= hs_s1;
      vs_s1        <= vsync_n_i;
      vs_s2        <= vs_s1;
      rgb_s1       <= rgb_i;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      vpend_q      <= vpend_d;
      state_q      <= state_d;
      map_we_o     <= sample;
      frame_done_o <= sample & last_cell;
      bad_color_o  <= sample & ~code_ok;
      sync_err_o   <= viol;
      locked_o     <= (state_d == S_LOCKED);
      if (sample) begin
        map_addr_o <= {cell_row, cell_col};
        map_data_o <= code;
      end
    end
  end

endmodule

// File: tb/tb_vgachargen_color_capture.sv
// Bench for vgachargen_color_capture on a reduced raster (8x3 cells): drives sync/pixel
// streams and scores every color-map write against expectations derived from the pixels driven.
module tb_vgachargen_color_capture;

  localparam int HR = 8,  HB = 8, HD = 64, HF = 4, HT = HR + HB + HD + HF;
  localparam int VR = 2,  VB = 4, VD = 48, VF = 2, VT = VR + VB + VD + VF;
  localparam int COLS = HD / 8, ROWS = VD / 16;
  localparam int M_FF = 0, M_CODE = 1, M_RAND = 2;

  logic        clk = 1'b0;
  logic        rst, hsync_n, vsync_n;
  logic [11:0] rgb;
  logic        map_we, locked, frame_done, bad_color, sync_err;
  logic [11:0] map_addr;
  logic [3:0]  map_data;

  vgachargen_color_capture #(
    .SAMPLE_X(4), .SAMPLE_Y(8),
    .HD(HD), .HF(HF), .HR(HR), .HB(HB),
    .VD(VD), .VF(VF), .VR(VR), .VB(VB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .hsync_n_i(hsync_n), .vsync_n_i(vsync_n), .rgb_i(rgb),
    .map_we_o(map_we), .map_addr_o(map_addr), .map_data_o(map_data), .locked_o(locked),
    .frame_done_o(frame_done), .bad_color_o(bad_color), .sync_err_o(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int addr; int data; int bad; int done;} exp_t;
  exp_t q[$];

  logic [11:0] pal [16] = '{12'h000, 12'h000, 12'h00d, 12'h00f, 12'hd00, 12'hf00, 12'hd0d, 12'hf0f,
                            12'h0d0, 12'h0f0, 12'h0dd, 12'h0ff, 12'hdd0, 12'hff0, 12'hddd, 12'hfff};
  logic [11:0] cell_rgb [COLS*ROWS];

  int cyc = 0;
  int n_total = 0, n_bad = 0;
  int wr_cnt, bad_cnt, done_cnt, err_cnt;
  int exp_wr, exp_bad, exp_done, exp_err;
  int cur_mode;
  bit m_locked, m_have, short_pend, chk_drop;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int enc(input logic [11:0] v);
    for (int i = 0; i < 16; i++) if (pal[i] == v) return i;
    return -1;
  endfunction

  task automatic check_cleared(input string pfx);
    check({pfx, "_we"}, map_we, 0);
    check({pfx, "_addr"}, map_addr, 0);
    check({pfx, "_data"}, map_data, 0);
    check({pfx, "_locked"}, locked, 0);
    check({pfx, "_done"}, frame_done, 0);
    check({pfx, "_bad"}, bad_color, 0);
    check({pfx, "_err"}, sync_err, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sync_err) err_cnt++;
    if (map_we) begin
      wr_cnt++;
      if (bad_color)  bad_cnt++;
      if (frame_done) done_cnt++;
      if (q.size() == 0) check("we_spurious", map_we, 0);
      else begin
        e = q.pop_front();
        check("we_cycle", cyc, e.cyc);
        check("we_addr", map_addr, e.addr);
        check("we_data", map_data, e.data);
        check("we_bad", bad_color, e.bad);
        check("we_done", frame_done, e.done);
      end
    end else begin
      if (bad_color || frame_done) check("stray_flag", {bad_color, frame_done}, 0);
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        check("we_missing", map_we, 1);
      end
    end
  end

  task automatic drive_line(input int line, input int len, input int rst_h);
    int x, y, r, c, code;
    logic [11:0] px;
    exp_t e;
    if (short_pend) begin
      short_pend = 0; m_locked = 0; m_have = 0; exp_err++; chk_drop = 1;
    end else begin
      if (line == 0 && m_have) m_locked = 1;
      m_have = 1;
    end
    short_pend = (len != HT);
    for (int h = 0; h < len; h++) begin
      @(posedge clk); #1;
      if (chk_drop && h == 5) begin check("locked_drop", locked, 0); chk_drop = 0; end
      if (rst_h >= 0 && h == rst_h + 1) check_cleared("midrst");
      rst = (h == rst_h);
      if (rst) begin
        m_locked = 0; m_have = 0;
        while (q.size() > 0 && q[q.size()-1].cyc > cyc) begin
          e = q.pop_back();
          exp_wr--; exp_bad -= e.bad; exp_done -= e.done;
        end
      end
      hsync_n = (h >= HR);
      vsync_n = (line >= VR);
      x = h - HR - HB;
      y = line - VR - VB;
      px = (cur_mode == M_FF) ? 12'hfff : 12'($urandom_range(0, 4095));
      if (x >= 0 && x < HD && y >= 0 && y < VD && x % 8 == 4 && y % 16 == 8) begin
        r = y / 16; c = x / 8;
        case (cur_mode)
          M_CODE:  px = pal[(r * 80 + c) % 16];
          M_RAND:  px = cell_rgb[r * COLS + c];
          default: px = 12'hfff;
        endcase
        if (m_locked) begin
          code = enc(px);
          e.cyc = cyc + 2; e.addr = r * 128 + c;
          e.data = (code < 0) ? 0 : code; e.bad = (code < 0);
          e.done = (r == ROWS - 1 && c == COLS - 1);
          q.push_back(e);
          exp_wr++; exp_bad += e.bad; exp_done += e.done;
        end
      end
      rgb = px;
    end
  endtask

  task automatic run_frame(input int short_line, input int rst_line);
    wr_cnt = 0; bad_cnt = 0; done_cnt = 0; err_cnt = 0;
    exp_wr = 0; exp_bad = 0; exp_done = 0; exp_err = 0;
    foreach (cell_rgb[i])
      case ($urandom_range(0, 3))
        0:       cell_rgb[i] = 12'($urandom_range(0, 4095));
        1:       cell_rgb[i] = 12'h8d0;
        default: cell_rgb[i] = pal[$urandom_range(0, 15)];
      endcase
    cell_rgb[0] = 12'h123;
    for (int l = 0; l < VT; l++)
      drive_line(l, (l == short_line) ? HT - 1 : HT, (l == rst_line) ? 30 : -1);
    check("frame_writes", wr_cnt, exp_wr);
    check("frame_bad", bad_cnt, exp_bad);
    check("frame_done", done_cnt, exp_done);
    check("frame_sync_err", err_cnt, exp_err);
    check("frame_locked", locked, int'(m_locked));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d limit=100000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hsync_n = 1'b1; vsync_n = 1'b1; rgb = '0;
    m_locked = 0; m_have = 0; short_pend = 0; chk_drop = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    @(posedge clk); #1 rst = 1'b0;

    cur_mode = M_FF;
    for (int l = VT - 5; l < VT; l++) drive_line(l, HT, -1);
    run_frame(-1, -1);
    check("t1_locked_f1", locked, 1);
    for (int f = 0; f < 2; f++) begin
      run_frame(-1, -1);
      check("t1_writes", wr_cnt, COLS * ROWS);
      check("t1_done", done_cnt, 1);
    end

    cur_mode = M_CODE;
    run_frame(-1, -1);
    check("t2_bad", bad_cnt, 0);

    cur_mode = M_RAND;
    run_frame(-1, -1);
    run_frame(VR + VB + 20, -1);
    check("t4_err", err_cnt, 1);
    run_frame(-1, -1);
    check("t4_relock", locked, 1);
    run_frame(-1, VR + VB + 10);
    run_frame(-1, -1);
    check("t6_writes", wr_cnt, COLS * ROWS);

    repeat (4) @(posedge clk);
    #1 check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
